// File: rtl/cop0_exc.sv
// Coprocessor-0 for the MIPS core: Count/Compare/Status/Cause/EPC/ErrorEPC, event
// prioritisation (exception > syscall/break > eret > interrupt) and a registered fetch redirect.
module cop0_exc #(
    parameter int          NUM_HW_INT  = 5,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_3000,
    parameter logic [31:0] BOOT_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic [2:0]            cop_op,
    input  logic [4:0]            reg_num,
    input  logic                  reg_wr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    input  logic [31:0]           pc_in,
    input  logic                  in_delay,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic                  int_pending
);

    localparam logic [2:0] COP_OP_MV  = 3'd0;
    localparam logic [2:0] COP_OP_EN  = 3'd1;
    localparam logic [2:0] COP_OP_DIS = 3'd2;
    localparam logic [2:0] COP_OP_RET = 3'd3;
    localparam logic [2:0] COP_OP_SYS = 3'd4;
    localparam logic [2:0] COP_OP_BRK = 3'd5;

    localparam logic [4:0] REG_COUNT     = 5'd9;
    localparam logic [4:0] REG_COMPARE   = 5'd11;
    localparam logic [4:0] REG_STATUS    = 5'd12;
    localparam logic [4:0] REG_CAUSE     = 5'd13;
    localparam logic [4:0] REG_EPC       = 5'd14;
    localparam logic [4:0] REG_ERROR_EPC = 5'd30;

    localparam logic [4:0]  EXC_INT      = 5'd0;
    localparam logic [4:0]  EXC_SYS      = 5'd8;
    localparam logic [4:0]  EXC_BP       = 5'd9;
    localparam logic [31:0] STATUS_MASK  = 32'h0040_FF07;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0001;
    localparam int          DIV_W        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [31:0]      count;
    logic [31:0]      compare;
    logic [31:0]      status;
    logic [31:0]      epc;
    logic [31:0]      error_epc;
    logic             cause_bd;
    logic             cause_ti;
    logic [4:0]       ip_hw;
    logic [1:0]       ip_sw;
    logic [4:0]       cause_exc;
    logic [DIV_W-1:0] div_cnt;

    logic [4:0]  hw_ext;
    logic [7:0]  cause_ip;
    logic [31:0] cause;
    logic [31:0] count_inc;
    logic [4:0]  entry_code;
    logic        tick;
    logic        accept;
    logic        take_exc;
    logic        take_sys;
    logic        take_ret;
    logic        take_int;
    logic        take_entry;
    logic        run_op;
    logic        mtc0;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;

    // NOTE: default every always_comb output first so no path leaves a latch behind.
    always_comb begin
        hw_ext = '0;
        hw_ext[NUM_HW_INT-1:0] = hw_int;
    end

    assign cause_ip    = {cause_ti, ip_hw, ip_sw};
    assign cause       = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};
    assign int_pending = status[0] & ~status[1] & ~status[2] & (|(cause_ip & status[15:8]));

    // The instruction in a redirect cycle is being flushed, so nothing is accepted then.
    assign accept     = ~redirect;
    assign take_exc   = accept & exc_req;
    assign take_sys   = accept & op_valid & ~exc_req &
                        ((cop_op == COP_OP_SYS) || (cop_op == COP_OP_BRK));
    assign take_ret   = accept & op_valid & ~exc_req & (cop_op == COP_OP_RET);
    assign take_int   = accept & ~exc_req & ~take_sys & ~take_ret & int_pending;
    assign take_entry = take_exc | take_sys | take_int;
    assign run_op     = accept & op_valid & ~exc_req & ~take_int;
    assign mtc0       = run_op & (cop_op == COP_OP_MV) & reg_wr;
    assign wr_count   = mtc0 & (reg_num == REG_COUNT);
    assign wr_compare = mtc0 & (reg_num == REG_COMPARE);
    assign wr_status  = mtc0 & (reg_num == REG_STATUS);

    assign entry_code = take_exc ? exc_code :
                        take_sys ? ((cop_op == COP_OP_BRK) ? EXC_BP : EXC_SYS) : EXC_INT;

    assign tick      = (div_cnt == DIV_W'(COUNT_DIV - 1));
    assign count_inc = count + 32'd1;

    always_comb begin
        rd_data = '0;
        if (op_valid) begin
            case (cop_op)
                COP_OP_MV: begin
                    case (reg_num)
                        REG_COUNT:     rd_data = count;
                        REG_COMPARE:   rd_data = compare;
                        REG_STATUS:    rd_data = status;
                        REG_CAUSE:     rd_data = cause;
                        REG_EPC:       rd_data = epc;
                        REG_ERROR_EPC: rd_data = error_epc;
                        default:       rd_data = '0;
                    endcase
                end
                COP_OP_EN, COP_OP_DIS: rd_data = status;
                default:               rd_data = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            compare     <= '0;
            status      <= STATUS_RESET;
            epc         <= '0;
            error_epc   <= '0;
            cause_bd    <= 1'b0;
            cause_ti    <= 1'b0;
            ip_hw       <= '0;
            ip_sw       <= '0;
            cause_exc   <= '0;
            div_cnt     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            ip_hw   <= hw_ext;

            // A software write to Count overrides the increment and suppresses the match.
            if (wr_count) begin
                count <= wr_data;
            end else if (tick) begin
                count <= count_inc;
            end

            if (wr_compare) begin
                compare  <= wr_data;
                cause_ti <= 1'b0;
            end else if (tick && !wr_count && (count_inc == compare)) begin
                cause_ti <= 1'b1;
            end

            if (wr_status) begin
                status <= wr_data & STATUS_MASK;
            end else if (take_entry) begin
                status[1] <= 1'b1;
            end else if (take_ret) begin
                if (status[2]) begin
                    status[2] <= 1'b0;
                end else begin
                    status[1] <= 1'b0;
                end
            end else if (run_op && (cop_op == COP_OP_EN)) begin
                status[0] <= 1'b1;
            end else if (run_op && (cop_op == COP_OP_DIS)) begin
                status[0] <= 1'b0;
            end

            if (mtc0 && (reg_num == REG_CAUSE)) begin
                ip_sw <= wr_data[9:8];
            end

            // A nested entry (EXL already set) keeps the original return address.
            if (take_entry) begin
                cause_exc <= entry_code;
                if (!status[1]) begin
                    epc      <= in_delay ? pc_in - 32'd4 : pc_in;
                    cause_bd <= in_delay;
                end
            end else if (mtc0 && (reg_num == REG_EPC)) begin
                epc <= wr_data;
            end

            if (mtc0 && (reg_num == REG_ERROR_EPC)) begin
                error_epc <= wr_data;
            end

            redirect <= take_entry | take_ret;
            if (take_entry) begin
                redirect_pc <= status[22] ? BOOT_VECTOR : EXC_VECTOR;
            end else if (take_ret) begin
                redirect_pc <= status[2] ? error_epc : epc;
            end
        end
    end

endmodule

// File: tb/tb_cop0_exc.sv
// Self-checking bench for cop0_exc: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a field-level reference model.
module tb_cop0_exc;

    localparam int          NHW    = 5;
    localparam int          CDIV   = 2;
    localparam logic [31:0] EXC_V  = 32'h0000_3000;
    localparam logic [31:0] BOOT_V = 32'hBFC0_0380;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_EN  = 3'd1;
    localparam logic [2:0] OP_DIS = 3'd2;
    localparam logic [2:0] OP_RET = 3'd3;
    localparam logic [2:0] OP_SYS = 3'd4;
    localparam logic [2:0] OP_BRK = 3'd5;

    logic           clk;
    logic           rst_n;
    logic           op_valid;
    logic [2:0]     cop_op;
    logic [4:0]     reg_num;
    logic           reg_wr;
    logic [31:0]    wr_data;
    logic [31:0]    rd_data;
    logic [31:0]    pc_in;
    logic           in_delay;
    logic           exc_req;
    logic [4:0]     exc_code;
    logic [NHW-1:0] hw_int;
    logic           redirect;
    logic [31:0]    redirect_pc;
    logic           int_pending;

    int total = 0;
    int bad   = 0;

    cop0_exc #(
        .NUM_HW_INT (NHW),
        .COUNT_DIV  (CDIV),
        .EXC_VECTOR (EXC_V),
        .BOOT_VECTOR(BOOT_V)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .cop_op     (cop_op),
        .reg_num    (reg_num),
        .reg_wr     (reg_wr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .pc_in      (pc_in),
        .in_delay   (in_delay),
        .exc_req    (exc_req),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .int_pending(int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        ov;
        logic [2:0]  op;
        logic [4:0]  rn;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        dly;
        logic        exc;
        logic [4:0]  code;
        logic [4:0]  hw;
        logic [31:0] exp_rd;
        logic        exp_ip;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [2:0] op, input logic [4:0] rn,
                                input logic wr, input logic [31:0] wd, input logic [31:0] pc,
                                input logic dly, input logic exc, input logic [4:0] code,
                                input logic [4:0] hw, input logic [31:0] erd, input logic eip,
                                input logic ered, input logic [31:0] epc);
        vec_t v;
        v.name = nm; v.ov = 1'b1; v.op = op; v.rn = rn; v.wr = wr; v.wd = wd; v.pc = pc;
        v.dly = dly; v.exc = exc; v.code = code; v.hw = hw; v.exp_rd = erd; v.exp_ip = eip;
        v.exp_redir = ered; v.exp_pc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op_valid = 1'b0; cop_op = OP_MV; reg_num = '0; reg_wr = 1'b0; wr_data = '0;
        pc_in = '0; in_delay = 1'b0; exc_req = 1'b0; exc_code = '0; hw_int = '0;
    endtask

    task automatic set_op(input logic [2:0] o, input logic [4:0] rn, input logic w,
                          input logic [31:0] d);
        op_valid = 1'b1; cop_op = o; reg_num = rn; reg_wr = w; wr_data = d;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] rn, input logic [31:0] exp);
        set_op(OP_MV, rn, 1'b0, 32'd0);
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("reset_redirect", 32'(redirect), 32'd0);
        check("reset_int_pending", 32'(int_pending), 32'd0);
    endtask

    // Reference model: CP0 state kept as separate architectural fields.
    int          m_edges;
    bit [31:0]   m_count, m_compare, m_epc, m_eepc, m_rpc;
    bit          m_ie, m_exl, m_erl, m_bev, m_bd, m_ti, m_redir;
    bit [7:0]    m_im;
    bit [1:0]    m_sw;
    bit [4:0]    m_hw, m_code;

    task automatic model_reset();
        m_edges = 0; m_count = 0; m_compare = 0; m_epc = 0; m_eepc = 0; m_rpc = 0;
        m_ie = 1; m_exl = 0; m_erl = 0; m_bev = 1; m_bd = 0; m_ti = 0; m_redir = 0;
        m_im = 0; m_sw = 0; m_hw = 0; m_code = 0;
    endtask

    function automatic bit [31:0] m_status();
        bit [31:0] s;
        s = 0;
        s[0] = m_ie; s[1] = m_exl; s[2] = m_erl; s[15:8] = m_im; s[22] = m_bev;
        return s;
    endfunction

    function automatic bit [7:0] m_ip();
        return {m_ti, m_hw, m_sw};
    endfunction

    function automatic bit [31:0] m_cause();
        bit [31:0] c;
        c = 0;
        c[31] = m_bd; c[30] = m_ti; c[15:8] = m_ip(); c[6:2] = m_code;
        return c;
    endfunction

    function automatic bit m_pending();
        return m_ie && !m_exl && !m_erl && ((m_ip() & m_im) != 0);
    endfunction

    function automatic bit [31:0] m_rd();
        if (!op_valid) return 0;
        if (cop_op == OP_EN || cop_op == OP_DIS) return m_status();
        if (cop_op != OP_MV) return 0;
        case (reg_num)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd30:   return m_eepc;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit        acc, tick, wrt;
        int        ev;
        bit [4:0]  code;
        bit [31:0] nxt;
        acc  = !m_redir;
        tick = ((m_edges + 1) % CDIV) == 0;
        ev   = 0;
        code = 0;
        if (acc) begin
            if (exc_req) begin ev = 1; code = exc_code; end
            else if (op_valid && cop_op == OP_SYS) begin ev = 1; code = 5'd8; end
            else if (op_valid && cop_op == OP_BRK) begin ev = 1; code = 5'd9; end
            else if (op_valid && cop_op == OP_RET) ev = 2;
            else if (m_pending()) begin ev = 1; code = 5'd0; end
        end
        wrt = acc && ev == 0 && op_valid && cop_op == OP_MV && reg_wr;
        nxt = m_count + 1;
        if (wrt && reg_num == 5'd11) m_ti = 0;
        else if (tick && !(wrt && reg_num == 5'd9) && nxt == m_compare) m_ti = 1;
        if (wrt && reg_num == 5'd9) m_count = wr_data;
        else if (tick) m_count = nxt;
        if (wrt && reg_num == 5'd11) m_compare = wr_data;
        m_hw = hw_int;
        if (ev == 1) begin
            m_rpc = m_bev ? BOOT_V : EXC_V;
            if (!m_exl) begin
                m_epc = in_delay ? pc_in - 4 : pc_in;
                m_bd  = in_delay;
            end
            m_code = code;
            m_exl  = 1;
        end else if (ev == 2) begin
            if (m_erl) begin m_rpc = m_eepc; m_erl = 0; end
            else begin m_rpc = m_epc; m_exl = 0; end
        end else if (acc && op_valid) begin
            if (cop_op == OP_EN) m_ie = 1;
            if (cop_op == OP_DIS) m_ie = 0;
            if (wrt && reg_num == 5'd12) begin
                m_ie = wr_data[0]; m_exl = wr_data[1]; m_erl = wr_data[2];
                m_im = wr_data[15:8]; m_bev = wr_data[22];
            end
            if (wrt && reg_num == 5'd13) m_sw = wr_data[9:8];
            if (wrt && reg_num == 5'd14) m_epc = wr_data;
            if (wrt && reg_num == 5'd30) m_eepc = wr_data;
        end
        m_redir = (ev != 0);
        m_edges++;
    endtask

    task automatic rand_inputs();
        int r;
        op_valid = ($urandom_range(0, 99) < 60);
        r = $urandom_range(0, 99);
        cop_op = (r < 55) ? OP_MV : (r < 63) ? OP_EN : (r < 71) ? OP_DIS : (r < 80) ? OP_RET :
                 (r < 88) ? OP_SYS : (r < 95) ? OP_BRK : 3'($urandom_range(6, 7));
        case ($urandom_range(0, 6))
            0:       reg_num = 5'd9;
            1:       reg_num = 5'd11;
            2:       reg_num = 5'd12;
            3:       reg_num = 5'd13;
            4:       reg_num = 5'd14;
            5:       reg_num = 5'd30;
            default: reg_num = 5'($urandom);
        endcase
        reg_wr  = 1'($urandom);
        wr_data = $urandom;
        if (reg_num == 5'd11) wr_data = m_count + $urandom_range(0, 6);
        if (reg_num == 5'd12 && $urandom_range(0, 3) != 0) begin
            wr_data[2:1] = 2'b00;
            wr_data[0]   = 1'b1;
        end
        pc_in    = $urandom & 32'hFFFF_FFFC;
        in_delay = 1'($urandom);
        exc_req  = ($urandom_range(0, 99) < 4);
        exc_code = 5'($urandom);
        hw_int   = ($urandom_range(0, 99) < 15) ? NHW'($urandom) : '0;
    endtask

    vec_t vt[26];
    int   n;
    bit   fired;

    initial begin
        rst_n = 1'b0;
        idle();

        vt[0]  = mk("rst_status",     OP_MV,  12, 0, 0,            0,      0, 0, 0,  0, 32'h0040_0001, 0, 0, 0);
        vt[1]  = mk("rst_cause",      OP_MV,  13, 0, 0,            0,      0, 0, 0,  0, 32'h0,         0, 0, 0);
        vt[2]  = mk("rst_errorepc",   OP_MV,  30, 0, 0,            0,      0, 0, 0,  0, 32'h0,         0, 0, 0);
        vt[3]  = mk("rst_epc",        OP_MV,  14, 0, 0,            0,      0, 0, 0,  0, 32'h0,         0, 0, 0);
        vt[4]  = mk("wr_status",      OP_MV,  12, 1, 32'h401,      0,      0, 0, 0,  0, 32'h0040_0001, 0, 0, 0);
        vt[5]  = mk("prio_event",     OP_SYS, 0,  0, 0,            32'h400,1, 1, 12, 1, 32'h0,         0, 1, EXC_V);
        vt[6]  = mk("prio_epc",       OP_MV,  14, 0, 0,            0,      0, 0, 0,  0, 32'h3FC,       0, 0, 0);
        vt[7]  = mk("prio_cause",     OP_MV,  13, 0, 0,            0,      0, 0, 0,  0, 32'h8000_0030, 0, 0, 0);
        vt[8]  = mk("nest_sys",       OP_SYS, 0,  0, 0,            32'h500,0, 0, 0,  0, 32'h0,         0, 1, EXC_V);
        vt[9]  = mk("flush_sys",      OP_SYS, 0,  0, 0,            32'h600,0, 0, 0,  0, 32'h0,         0, 0, 0);
        vt[10] = mk("nest_epc",       OP_MV,  14, 0, 0,            0,      0, 0, 0,  0, 32'h3FC,       0, 0, 0);
        vt[11] = mk("nest_cause",     OP_MV,  13, 0, 0,            0,      0, 0, 0,  0, 32'h8000_0020, 0, 0, 0);
        vt[12] = mk("eret_exl",       OP_RET, 0,  0, 0,            0,      0, 0, 0,  0, 32'h0,         0, 1, 32'h3FC);
        vt[13] = mk("exl_clear",      OP_MV,  12, 0, 0,            0,      0, 0, 0,  0, 32'h401,       0, 0, 0);
        vt[14] = mk("wr_errorepc",    OP_MV,  30, 1, 32'h1234,     0,      0, 0, 0,  0, 32'h0,         0, 0, 0);
        vt[15] = mk("wr_status_mask", OP_MV,  12, 1, 32'hFFFF_FFFF,0,      0, 0, 0,  0, 32'h401,       0, 0, 0);
        vt[16] = mk("status_masked",  OP_MV,  12, 0, 0,            0,      0, 0, 0,  0, 32'h0040_FF07, 0, 0, 0);
        vt[17] = mk("eret_erl",       OP_RET, 0,  0, 0,            0,      0, 0, 0,  0, 32'h0,         0, 1, 32'h1234);
        vt[18] = mk("erl_clear",      OP_MV,  12, 0, 0,            0,      0, 0, 0,  0, 32'h0040_FF03, 0, 0, 0);
        vt[19] = mk("di",             OP_DIS, 0,  0, 0,            0,      0, 0, 0,  0, 32'h0040_FF03, 0, 0, 0);
        vt[20] = mk("ei",             OP_EN,  0,  0, 0,            0,      0, 0, 0,  0, 32'h0040_FF02, 0, 0, 0);
        vt[21] = mk("ie_set",         OP_MV,  12, 0, 0,            0,      0, 0, 0,  0, 32'h0040_FF03, 0, 0, 0);
        vt[22] = mk("wr_unimpl",      OP_MV,  5,  1, 32'hDEAD,     0,      0, 0, 0,  0, 32'h0,         0, 0, 0);
        vt[23] = mk("rd_unimpl",      OP_MV,  5,  0, 0,            0,      0, 0, 0,  0, 32'h0,         0, 0, 0);
        vt[24] = mk("wr_cause",       OP_MV,  13, 1, 32'hFFFF_FFFF,0,      0, 0, 0,  0, 32'h8000_0020, 0, 0, 0);
        vt[25] = mk("cause_soft",     OP_MV,  13, 0, 0,            0,      0, 0, 0,  0, 32'h8000_0320, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            op_valid = vt[i].ov;  cop_op = vt[i].op;   reg_num = vt[i].rn;   reg_wr = vt[i].wr;
            wr_data  = vt[i].wd;  pc_in  = vt[i].pc;   in_delay = vt[i].dly; exc_req = vt[i].exc;
            exc_code = vt[i].code; hw_int = vt[i].hw;
            #1;
            check({vt[i].name, "_rd"}, rd_data, vt[i].exp_rd);
            check({vt[i].name, "_ip"}, 32'(int_pending), 32'(vt[i].exp_ip));
            step();
            check({vt[i].name, "_redir"}, 32'(redirect), 32'(vt[i].exp_redir));
            if (vt[i].exp_redir) check({vt[i].name, "_pc"}, redirect_pc, vt[i].exp_pc);
        end

        // Timer interrupt: Compare=5 with Count advancing every second clock.
        do_reset();
        n = 0;
        set_op(OP_MV, 11, 1'b1, 32'd5);
        step(); n++;
        set_op(OP_MV, 12, 1'b1, 32'h0000_8001);
        step(); n++;
        idle();
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            #1;
            if (int_pending) fired = 1'b1;
            else begin
                step(); n++;
            end
        end
        check("timer_fired", 32'(fired), 32'd1);
        check("timer_latency", 32'(n), 32'd10);
        rd_chk("timer_count", 9, 32'd5);
        step();
        check("timer_redir", 32'(redirect), 32'd1);
        check("timer_redir_pc", redirect_pc, EXC_V);
        rd_chk("timer_cause", 13, 32'h4000_8000);
        step();
        rd_chk("timer_status", 12, 32'h0000_8003);
        step();
        set_op(OP_MV, 11, 1'b1, 32'd100);
        step();
        rd_chk("timer_ti_clear", 13, 32'h0);

        // Count wrap (matches Compare=0) and mtc0 Count colliding with an increment.
        do_reset();
        set_op(OP_MV, 9, 1'b1, 32'hFFFF_FFFE);
        step();
        rd_chk("count_load", 9, 32'hFFFF_FFFE);
        step();
        rd_chk("count_max", 9, 32'hFFFF_FFFF);
        step();
        step();
        rd_chk("count_wrap", 9, 32'h0);
        rd_chk("wrap_ti", 13, 32'h4000_8000);
        step();
        set_op(OP_MV, 9, 1'b1, 32'd7);
        step();
        rd_chk("count_collision", 9, 32'd7);
        step();
        step();
        rd_chk("count_after_collision", 9, 32'd8);

        // Reset during a redirect pulse; boot vector while BEV=1.
        do_reset();
        set_op(OP_SYS, 0, 1'b0, 32'd0);
        pc_in = 32'h100;
        step();
        check("boot_redir", 32'(redirect), 32'd1);
        check("boot_redir_pc", redirect_pc, BOOT_V);
        idle();
        rst_n = 1'b0;
        step();
        check("rst_kills_redirect", 32'(redirect), 32'd0);
        rst_n = 1'b1;
        rd_chk("rst_status_after", 12, 32'h0040_0001);

        // Interrupt pending across an eret waits out the flush cycle.
        do_reset();
        hw_int = 5'b00010;
        set_op(OP_MV, 12, 1'b1, 32'h0000_0803);
        step();
        set_op(OP_RET, 0, 1'b0, 32'd0);
        #1;
        check("ret_cycle_pending", 32'(int_pending), 32'd0);
        step();
        check("ret_redir", 32'(redirect), 32'd1);
        check("ret_redir_pc", redirect_pc, 32'h0);
        op_valid = 1'b0;
        #1;
        check("pending_in_flush", 32'(int_pending), 32'd1);
        step();
        check("no_take_in_flush", 32'(redirect), 32'd0);
        check("pending_after_flush", 32'(int_pending), 32'd1);
        step();
        check("int_after_ret", 32'(redirect), 32'd1);
        check("int_after_ret_pc", redirect_pc, EXC_V);
        rd_chk("int_cause", 13, 32'h0000_0800);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            #1;
            check("rand_rd_data", rd_data, m_rd());
            check("rand_int_pending", 32'(int_pending), 32'(m_pending()));
            check("rand_redirect", 32'(redirect), 32'(m_redir));
            if (m_redir) check("rand_redirect_pc", redirect_pc, m_rpc);
            model_step();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
